// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-arithmetic monitors: FSM state
// encoding, default operand width and the counter/accumulator width helpers.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_W = 4;

  // Width of a counter that must hold values 0..nsamp inclusive.
  function automatic int cnt_w(input int nsamp);
    return $clog2(nsamp + 1);
  endfunction

  // Width of a sum of nsamp error distances, each at most w+1 bits wide.
  function automatic int sum_w(input int w, input int nsamp);
    return w + 1 + $clog2(nsamp + 1);
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample stream, control and result bundle of the error monitor.
// master = sample source / result consumer, slave = the monitor itself.
interface approx_err_monitor_if
  import approx_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NSAMP = 256
);
  localparam int CNT_W = cnt_w(NSAMP);
  localparam int SUM_W = sum_w(W, NSAMP);

  logic             START;
  logic             CLEAR;
  logic             VALID_IN;
  logic             READY_IN;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [W:0]       Y_APX;
  logic             RES_VALID;
  logic             RES_READY;
  logic [CNT_W-1:0] ERR_CNT;
  logic [SUM_W-1:0] ED_SUM;
  logic [W:0]       ED_MAX;
  logic [CNT_W-1:0] SAMP_CNT;

  modport master (
    output START, CLEAR, VALID_IN, A, B, Y_APX, RES_READY,
    input  READY_IN, RES_VALID, ERR_CNT, ED_SUM, ED_MAX, SAMP_CNT
  );

  modport slave (
    input  START, CLEAR, VALID_IN, A, B, Y_APX, RES_READY,
    output READY_IN, RES_VALID, ERR_CNT, ED_SUM, ED_MAX, SAMP_CNT
  );

endinterface

// File: rtl/approx_err_dist.sv
// Exact reference path: recomputes A+B and returns the unsigned distance to
// the approximate sum plus a flag for any non-zero distance.
module approx_err_dist #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   y_apx,
  output logic [W:0]   ed,
  output logic         err_flag
);

  logic [W:0] exact;

  // Absolute difference; both operands fit W+1 bits, so the result does too.
  always_comb begin
    exact    = {1'b0, a} + {1'b0, b};
    ed       = (exact >= y_apx) ? (exact - y_apx) : (y_apx - exact);
    err_flag = (ed != '0);
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Accumulates error count, error-distance sum and maximum error distance of
// an approximate adder over a window of NSAMP accepted samples, then offers
// the totals through a valid/ready handshake.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NSAMP = 256
) (
  input logic                  clk,
  input logic                  rst_n,
  approx_err_monitor_if.slave  bus
);

  localparam int CNT_W = cnt_w(NSAMP);
  localparam int SUM_W = sum_w(W, NSAMP);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSAMP - 1);

  state_e           state_q, state_d;
  logic             clr_acc;
  logic             accept;
  logic [W:0]       ed;
  logic             err_flag;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] samp_cnt_q;
  logic [SUM_W-1:0] ed_sum_q;
  logic [W:0]       ed_max_q;

  approx_err_dist #(.W(W)) u_dist (
    .a        (bus.A),
    .b        (bus.B),
    .y_apx    (bus.Y_APX),
    .ed       (ed),
    .err_flag (err_flag)
  );

  // Handshake outputs follow the state; CLEAR masks them in its own cycle.
  assign bus.READY_IN  = (state_q == RUN)  && !bus.CLEAR;
  assign bus.RES_VALID = (state_q == DONE) && !bus.CLEAR;

  assign bus.ERR_CNT  = err_cnt_q;
  assign bus.ED_SUM   = ed_sum_q;
  assign bus.ED_MAX   = ed_max_q;
  assign bus.SAMP_CNT = samp_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and accumulator control; CLEAR overrides every other event.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    clr_acc = 1'b0;
    accept  = 1'b0;
    if (bus.CLEAR) begin
      state_d = IDLE;
      clr_acc = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (bus.START) begin
          state_d = RUN;
          clr_acc = 1'b1;
        end
        RUN: if (bus.VALID_IN) begin
          accept = 1'b1;
          if (samp_cnt_q == LAST_IDX) state_d = DONE;
        end
        DONE: if (bus.RES_READY) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Window statistics; widths are sized so no accumulator can overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      ed_sum_q   <= '0;
      ed_max_q   <= '0;
      samp_cnt_q <= '0;
    end else if (clr_acc) begin
      err_cnt_q  <= '0;
      ed_sum_q   <= '0;
      ed_max_q   <= '0;
      samp_cnt_q <= '0;
    end else if (accept) begin
      err_cnt_q  <= err_cnt_q + CNT_W'(err_flag);
      ed_sum_q   <= ed_sum_q + SUM_W'(ed);
      samp_cnt_q <= samp_cnt_q + 1'b1;
      if (ed > ed_max_q) ed_max_q <= ed;
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor: windows of 4, 8 and 256 samples.
module tb_approx_err_monitor;
  import approx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  approx_err_monitor_if #(.W(4), .NSAMP(4))   bus4 ();
  approx_err_monitor_if #(.W(4), .NSAMP(8))   bus8 ();
  approx_err_monitor_if #(.W(4), .NSAMP(256)) bus256 ();

  approx_err_monitor #(.W(4), .NSAMP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  approx_err_monitor #(.W(4), .NSAMP(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  approx_err_monitor #(.W(4), .NSAMP(256)) u256 (
    .clk(clk), .rst_n(rst_n), .bus(bus256.slave));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] y;
    int         err;
    int         sum;
    int         max;
    int         samp;
    logic       rv;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Approximate adder with p=1: LSB is an OR, no carry out of bit 0.
  function automatic logic [4:0] apx_p1(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] hi;
    hi = {1'b0, a[3:1]} + {1'b0, b[3:1]};
    return {hi, a[0] | b[0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_err, g_sum, g_max, d;

    // Windows of 4: all-error window then a mixed window.
    tbl[0] = '{4'd1,  4'd1,  5'd3, 1, 1,  1,  1, 1'b0};
    tbl[1] = '{4'd1,  4'd1,  5'd3, 2, 2,  1,  2, 1'b0};
    tbl[2] = '{4'd1,  4'd1,  5'd3, 3, 3,  1,  3, 1'b0};
    tbl[3] = '{4'd1,  4'd1,  5'd3, 4, 4,  1,  4, 1'b1};
    tbl[4] = '{4'd0,  4'd0,  5'd0, 0, 0,  0,  1, 1'b0};
    tbl[5] = '{4'd1,  4'd0,  5'd1, 0, 0,  0,  2, 1'b0};
    tbl[6] = '{4'd3,  4'd1,  5'd5, 1, 1,  1,  3, 1'b0};
    tbl[7] = '{4'd15, 4'd15, 5'd0, 2, 31, 30, 4, 1'b1};

    {bus4.START, bus4.CLEAR, bus4.VALID_IN, bus4.RES_READY} = '0;
    {bus8.START, bus8.CLEAR, bus8.VALID_IN, bus8.RES_READY} = '0;
    {bus256.START, bus256.CLEAR, bus256.VALID_IN, bus256.RES_READY} = '0;
    {bus4.A, bus4.B, bus4.Y_APX} = '0;
    {bus8.A, bus8.B, bus8.Y_APX} = '0;
    {bus256.A, bus256.B, bus256.Y_APX} = '0;

    #12;
    check("rst_ready",  bus4.READY_IN,  0);
    check("rst_rvalid", bus4.RES_VALID, 0);
    check("rst_err",    bus4.ERR_CNT,   0);
    check("rst_sum",    bus4.ED_SUM,    0);
    check("rst_max",    bus4.ED_MAX,    0);
    check("rst_samp",   bus4.SAMP_CNT,  0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check("idle_ready", bus4.READY_IN, 0);

    // Tests 1 and 2: table-driven back-to-back accepts.
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) begin
        bus4.VALID_IN = 1'b0;
        if (i != 0) begin
          bus4.RES_READY = 1'b1;
          cyc();
          bus4.RES_READY = 1'b0;
          check("hold_after_hs", bus4.ERR_CNT, 4);
          check("idle_rvalid",   bus4.RES_VALID, 0);
        end
        bus4.START = 1'b1;
        cyc();
        bus4.START = 1'b0;
        check("start_clr_samp", bus4.SAMP_CNT, 0);
        check("run_ready",      bus4.READY_IN, 1);
      end
      bus4.VALID_IN = 1'b1;
      bus4.A = tbl[i].a;
      bus4.B = tbl[i].b;
      bus4.Y_APX = tbl[i].y;
      cyc();
      check($sformatf("v%0d_err", i),  bus4.ERR_CNT,   tbl[i].err);
      check($sformatf("v%0d_sum", i),  bus4.ED_SUM,    tbl[i].sum);
      check($sformatf("v%0d_max", i),  bus4.ED_MAX,    tbl[i].max);
      check($sformatf("v%0d_samp", i), bus4.SAMP_CNT,  tbl[i].samp);
      check($sformatf("v%0d_rv", i),   bus4.RES_VALID, tbl[i].rv);
    end

    // Test 3: DONE holds under back-pressure with VALID_IN still high.
    bus4.A = 4'd15; bus4.B = 4'd0; bus4.Y_APX = 5'd0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("done_ready", bus4.READY_IN,  0);
      check("done_rv",    bus4.RES_VALID, 1);
      check("done_sum",   bus4.ED_SUM,    31);
      check("done_samp",  bus4.SAMP_CNT,  4);
    end
    bus4.VALID_IN = 1'b0;
    bus4.RES_READY = 1'b1;
    bus4.START = 1'b1;
    cyc();
    bus4.RES_READY = 1'b0;
    bus4.START = 1'b0;
    check("hs_rv",   bus4.RES_VALID, 0);
    check("hs_sum",  bus4.ED_SUM,    31);
    check("hs_max",  bus4.ED_MAX,    30);
    cyc();
    check("hs_start_ignored", bus4.READY_IN, 0);

    // Test 4: CLEAR together with VALID_IN after 3 accepts.
    bus8.START = 1'b1;
    cyc();
    bus8.START = 1'b0;
    bus8.VALID_IN = 1'b1;
    bus8.A = 4'd1; bus8.B = 4'd1; bus8.Y_APX = 5'd3;
    repeat (3) cyc();
    check("c_pre_sum", bus8.ED_SUM, 3);
    bus8.CLEAR = 1'b1;
    cyc();
    bus8.CLEAR = 1'b0;
    check("c_err",   bus8.ERR_CNT,   0);
    check("c_sum",   bus8.ED_SUM,    0);
    check("c_max",   bus8.ED_MAX,    0);
    check("c_samp",  bus8.SAMP_CNT,  0);
    check("c_ready", bus8.READY_IN,  0);
    check("c_rv",    bus8.RES_VALID, 0);
    bus8.VALID_IN = 1'b0;
    bus8.START = 1'b1;
    cyc();
    bus8.START = 1'b0;
    bus8.VALID_IN = 1'b1;
    bus8.A = 4'd3; bus8.B = 4'd1; bus8.Y_APX = 5'd5;
    cyc();
    check("r_err",  bus8.ERR_CNT,  1);
    check("r_sum",  bus8.ED_SUM,   1);
    check("r_samp", bus8.SAMP_CNT, 1);

    // Test 5: START in RUN ignored, then asynchronous reset mid-window.
    bus8.A = 4'd2; bus8.B = 4'd3; bus8.Y_APX = 5'd5;
    bus8.START = 1'b1;
    repeat (2) cyc();
    bus8.START = 1'b0;
    repeat (2) cyc();
    check("m_samp", bus8.SAMP_CNT, 5);
    check("m_err",  bus8.ERR_CNT,  1);
    check("m_sum",  bus8.ED_SUM,   1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_err",   bus8.ERR_CNT,  0);
    check("ar_sum",   bus8.ED_SUM,   0);
    check("ar_samp",  bus8.SAMP_CNT, 0);
    check("ar_ready", bus8.READY_IN, 0);
    #10;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    check("ar_idle_samp",  bus8.SAMP_CNT, 0);
    check("ar_idle_ready", bus8.READY_IN, 0);
    bus8.VALID_IN = 1'b0;

    // Test 6: exhaustive 256-pair window through the p=1 model.
    g_err = 0; g_sum = 0; g_max = 0;
    bus256.START = 1'b1;
    cyc();
    bus256.START = 1'b0;
    bus256.VALID_IN = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      bus256.A = idx[7:4];
      bus256.B = idx[3:0];
      bus256.Y_APX = apx_p1(idx[7:4], idx[3:0]);
      d = int'(idx[7:4]) + int'(idx[3:0]) - int'(bus256.Y_APX);
      if (d < 0) d = -d;
      if (d != 0) g_err++;
      g_sum += d;
      if (d > g_max) g_max = d;
      cyc();
      check("x_rv", bus256.RES_VALID, (i == 255) ? 1 : 0);
    end
    bus256.VALID_IN = 1'b0;
    check("x_err",   bus256.ERR_CNT,  g_err);
    check("x_sum",   bus256.ED_SUM,   g_sum);
    check("x_max",   bus256.ED_MAX,   g_max);
    check("x_max1",  bus256.ED_MAX,   1);
    check("x_samp",  bus256.SAMP_CNT, 256);
    check("x_ready", bus256.READY_IN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
